wr_ptr_ctrl: RTL and testbench

Parametrised write-side pointer controller for the team's FIFOs. It keeps a wrap-bit write pointer for any depth up to 2^(D-1), not only powers of two. It compares that pointer against a read pointer already in the write domain and produces full, almost-full, fill level, overflow and a registered status state. It sits between the write port and the storage array, driving the array write address and gating write enable.

---
 rtl/wr_ptr_pkg.sv | 44 ++++
 rtl/wr_ptr_ctrl_wrap_ptr_cnt.sv | 50 +++++
 rtl/wr_ptr_ctrl.sv | 131 +++++++++++++
 tb/tb_wr_ptr_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wr_ptr_pkg.sv
// ---------------------------------------------------------------------------
// wr_ptr_pkg
// Shared definitions for the FIFO pointer controllers (write and read side).
//   wr_state_e  : 2-bit registered status encoding EMPTY/FILLING/AFULL/FULL
//   WR_STATE_W  : width of the status field
//   ptr_level() : occupancy from a pair of wrap-bit pointers for any depth
// ---------------------------------------------------------------------------
package wr_ptr_pkg;

    localparam int WR_STATE_W = 2;

    typedef enum logic [WR_STATE_W-1:0] {
        WS_EMPTY   = 2'd0,
        WS_FILLING = 2'd1,
        WS_AFULL   = 2'd2,
        WS_FULL    = 2'd3
    } wr_state_e;

    // Occupancy between a producer pointer and a consumer pointer, both
    // ptr_w bits wide with the wrap bit at ptr_w-1. Works at 32 bits so one
    // function serves every instance; callers truncate to their own width.
    // When the wrap bits differ the producer has lapped the array once, so
    // the count is the tail of the consumer's lap plus the producer's index.
    function automatic logic [31:0] ptr_level(
        input logic [31:0] prod_ptr,
        input logic [31:0] cons_ptr,
        input int unsigned ptr_w,
        input int unsigned depth
    );
        logic [31:0] idx_mask;
        logic [31:0] prod_idx;
        logic [31:0] cons_idx;
        logic        same_lap;
        idx_mask = (32'd1 << (ptr_w - 1)) - 32'd1;
        prod_idx = prod_ptr & idx_mask;
        cons_idx = cons_ptr & idx_mask;
        same_lap = (prod_ptr[ptr_w-1] == cons_ptr[ptr_w-1]);
        if (same_lap)
            return prod_idx - cons_idx;
        else
            return depth - cons_idx + prod_idx;
    endfunction

endpackage

// File: rtl/wr_ptr_ctrl_wrap_ptr_cnt.sv
// ---------------------------------------------------------------------------
// wrap_ptr_cnt
// Wrap-bit pointer counter for arbitrary (non power-of-two) depths.
// The index counts 0..DEPTH-1; on leaving DEPTH-1 it returns to 0 and the
// wrap bit (MSB) toggles. Shared by the write- and read-side controllers.
// Parameters:
//   D      pointer width, bit D-1 is the wrap bit
//   DEPTH  number of entries, 2 <= DEPTH <= 2^(D-1)
// Ports:
//   wrclk  in   clock
//   wrrst  in   asynchronous active-high reset
//   inc    in   advance the pointer on this edge
//   ptr    out  registered pointer {wrap, index}
// ---------------------------------------------------------------------------
module wrap_ptr_cnt #(
    parameter int D     = 8,
    parameter int DEPTH = 90
) (
    input  logic         wrclk,
    input  logic         wrrst,
    input  logic         inc,
    output logic [D-1:0] ptr
);

    localparam logic [D-2:0] LAST_IDX = (D-1)'(DEPTH - 1);
    localparam logic [D-2:0] ONE_IDX  = (D-1)'(1);

    logic [D-1:0] ptr_d;
    logic [D-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            if (ptr_q[D-2:0] == LAST_IDX)
                ptr_d = {~ptr_q[D-1], {(D-1){1'b0}}};
            else
                ptr_d = {ptr_q[D-1], ptr_q[D-2:0] + ONE_IDX};
        end
    end

    always_ff @(posedge wrclk or posedge wrrst) begin
        if (wrrst)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/wr_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// wr_ptr_ctrl
// Write-side pointer controller for the team FIFOs. Keeps the wrap-bit write
// pointer, compares it against the (already write-domain) read pointer and
// produces full / almost-full / level / overflow plus a registered status.
// Parameters:
//   D          pointer width (wrap bit at D-1)
//   DEPTH      entries, 2 <= DEPTH <= 2^(D-1)
//   AF_THRESH  almost_full asserts when level >= AF_THRESH
// Ports:
//   wrclk        in   write clock
//   wrrst        in   asynchronous active-high reset
//   wren         in   write request
//   rdPtr        in   read pointer synchronised to wrclk
//   wrPtr        out  registered write pointer
//   wr_addr      out  storage array address (wrPtr index)
//   wr_accept    out  array write strobe, wren & !fifo_full
//   fifo_full    out  combinational full
//   almost_full  out  combinational, level >= AF_THRESH
//   level        out  combinational occupancy 0..DEPTH
//   overflow     out  registered overflow indication
//   wr_state     out  registered status EMPTY/FILLING/AFULL/FULL
// Build option:
//   WR_PTR_OVF_STICKY_EN  defined   -> overflow sticks at 1 until reset
//                         undefined -> overflow pulses the cycle after each
//                                      rejected write
// ---------------------------------------------------------------------------
module wr_ptr_ctrl
    import wr_ptr_pkg::*;
#(
    parameter int D         = 8,
    parameter int DEPTH     = 90,
    parameter int AF_THRESH = DEPTH - 4
) (
    input  logic                  wrclk,
    input  logic                  wrrst,
    input  logic                  wren,
    input  logic [D-1:0]          rdPtr,
    output logic [D-1:0]          wrPtr,
    output logic [D-2:0]          wr_addr,
    output logic                  wr_accept,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic [D-1:0]          level,
    output logic                  overflow,
    output logic [WR_STATE_W-1:0] wr_state
);

    localparam logic [D-1:0] AF_LVL   = D'(AF_THRESH);
    localparam logic [D-1:0] FULL_LVL = D'(DEPTH);

    logic [D-1:0] wr_ptr;
    wr_state_e    state_d;
    wr_state_e    state_q;
    logic         ovf_d;
    logic         ovf_q;

    // Pointer counter advances only on accepted writes, so a write attempt
    // while full can never move it.
    wrap_ptr_cnt #(
        .D     (D),
        .DEPTH (DEPTH)
    ) u_wr_cnt (
        .wrclk (wrclk),
        .wrrst (wrrst),
        .inc   (wr_accept),
        .ptr   (wr_ptr)
    );

    assign wrPtr   = wr_ptr;
    assign wr_addr = wr_ptr[D-2:0];

    // Full: the writer is exactly one lap ahead of the reader.
    assign fifo_full   = (wr_ptr[D-1] != rdPtr[D-1]) && (wr_ptr[D-2:0] == rdPtr[D-2:0]);
    assign wr_accept   = wren & ~fifo_full;
    assign level       = D'(ptr_level(32'(wr_ptr), 32'(rdPtr), D, DEPTH));
    assign almost_full = (level >= AF_LVL);

    // Status state register
    always_ff @(posedge wrclk or posedge wrrst) begin
        if (wrrst)
            state_q <= WS_EMPTY;
        else
            state_q <= state_d;
    end

    // Next state comes straight from the current level; the read side may
    // drain many entries between samples so every transition is legal.
    // With AF_THRESH == DEPTH the AFULL band is empty and never selected.
    always_comb begin
        state_d = WS_FILLING;
        if (level == '0)
            state_d = WS_EMPTY;
        else if (level >= FULL_LVL)
            state_d = WS_FULL;
        else if (level >= AF_LVL)
            state_d = WS_AFULL;
    end

    // Status output
    always_comb begin
        wr_state = state_q;
    end

`ifdef WR_PTR_OVF_STICKY_EN
    always_comb begin
        ovf_d = ovf_q | (wren & fifo_full);
    end
`else
    always_comb begin
        ovf_d = wren & fifo_full;
    end
`endif

    always_ff @(posedge wrclk or posedge wrrst) begin
        if (wrrst)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end

    assign overflow = ovf_q;

`ifndef SYNTHESIS
    // A read index at or beyond DEPTH cannot come from a legal read pointer.
    localparam logic [D-2:0] LAST_IDX = (D-1)'(DEPTH - 1);
    a_rd_idx_legal: assert property (@(posedge wrclk) disable iff (wrrst)
        rdPtr[D-2:0] <= LAST_IDX);
`endif

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
module tb_wr_ptr_ctrl;

    localparam int D         = 8;
    localparam int DEPTH     = 90;
    localparam int AF_THRESH = 86;

    logic         wrclk;
    logic         wrrst;
    logic         wren;
    logic [D-1:0] rdPtr;
    logic [D-1:0] wrPtr;
    logic [D-2:0] wr_addr;
    logic         wr_accept;
    logic         fifo_full;
    logic         almost_full;
    logic [D-1:0] level;
    logic         overflow;
    logic [1:0]   wr_state;

    int n_vec;
    int n_bad;

    wr_ptr_ctrl #(
        .D         (D),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) dut (
        .wrclk       (wrclk),
        .wrrst       (wrrst),
        .wren        (wren),
        .rdPtr       (rdPtr),
        .wrPtr       (wrPtr),
        .wr_addr     (wr_addr),
        .wr_accept   (wr_accept),
        .fifo_full   (fifo_full),
        .almost_full (almost_full),
        .level       (level),
        .overflow    (overflow),
        .wr_state    (wr_state)
    );

    initial wrclk = 1'b0;
    always #5 wrclk = ~wrclk;

    typedef struct {
        logic       wren;
        logic [7:0] rd;
        logic [7:0] e_ptr;
        logic [7:0] e_lvl;
        logic       e_full;
        logic       e_af;
        logic       e_acc;
        logic       e_ovf;
        logic [1:0] e_st;
    } vec_t;

    vec_t tbl [8];

`ifdef WR_PTR_OVF_STICKY_EN
    localparam logic OVF_HOLD = 1'b1;
`else
    localparam logic OVF_HOLD = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Return to posedge+1, where inputs are driven.
    task automatic cyc();
        @(posedge wrclk);
        #1;
    endtask

    task automatic do_reset();
        wrrst = 1'b1;
        wren  = 1'b0;
        rdPtr = '0;
        repeat (2) @(posedge wrclk);
        #1;
        wrrst = 1'b0;
    endtask

    // Watchdog: everything is clock-paced, this only guards against a stall.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        wrrst = 1'b1;
        wren  = 1'b0;
        rdPtr = '0;

        //          wren rd     ptr    lvl  full af acc ovf st
        tbl[0] = '{1'b0, 8'h00, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[1] = '{1'b1, 8'h00, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[2] = '{1'b1, 8'h00, 8'h01, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[3] = '{1'b0, 8'h00, 8'h02, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[4] = '{1'b0, 8'h02, 8'h02, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[5] = '{1'b0, 8'h02, 8'h02, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[6] = '{1'b1, 8'h01, 8'h02, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[7] = '{1'b0, 8'h01, 8'h03, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};

        do_reset();

        // Table-driven basic behaviour, starting from reset state.
        for (int i = 0; i < 8; i++) begin
            wren  = tbl[i].wren;
            rdPtr = tbl[i].rd;
            @(negedge wrclk);
            chk($sformatf("t%0d_wrPtr", i),   32'(wrPtr),       32'(tbl[i].e_ptr));
            chk($sformatf("t%0d_wr_addr", i), 32'(wr_addr),     32'(tbl[i].e_ptr[6:0]));
            chk($sformatf("t%0d_level", i),   32'(level),       32'(tbl[i].e_lvl));
            chk($sformatf("t%0d_full", i),    32'(fifo_full),   32'(tbl[i].e_full));
            chk($sformatf("t%0d_afull", i),   32'(almost_full), 32'(tbl[i].e_af));
            chk($sformatf("t%0d_accept", i),  32'(wr_accept),   32'(tbl[i].e_acc));
            chk($sformatf("t%0d_ovf", i),     32'(overflow),    32'(tbl[i].e_ovf));
            chk($sformatf("t%0d_state", i),   32'(wr_state),    32'(tbl[i].e_st));
            cyc();
        end

        // Fill to full with rdPtr = 0.
        do_reset();
        wren = 1'b1;
        for (int k = 0; k < 90; k++) begin
            @(negedge wrclk);
            chk($sformatf("fill%0d_wrPtr", k),  32'(wrPtr),       32'(k));
            chk($sformatf("fill%0d_level", k),  32'(level),       32'(k));
            chk($sformatf("fill%0d_accept", k), 32'(wr_accept),   32'd1);
            chk($sformatf("fill%0d_afull", k),  32'(almost_full), (k >= 86) ? 32'd1 : 32'd0);
            if (k == 1)  chk("fill1_state",  32'(wr_state), 32'd0);
            if (k == 2)  chk("fill2_state",  32'(wr_state), 32'd1);
            if (k == 86) chk("fill86_state", 32'(wr_state), 32'd1);
            if (k == 87) chk("fill87_state", 32'(wr_state), 32'd2);
            cyc();
        end
        // Write 91 while full.
        @(negedge wrclk);
        chk("full_wrPtr",  32'(wrPtr),       32'h80);
        chk("full_level",  32'(level),       32'd90);
        chk("full_flag",   32'(fifo_full),   32'd1);
        chk("full_accept", 32'(wr_accept),   32'd0);
        chk("full_afull",  32'(almost_full), 32'd1);
        chk("full_state",  32'(wr_state),    32'd2);
        chk("full_ovf0",   32'(overflow),    32'd0);
        cyc();
        wren = 1'b0;
        @(negedge wrclk);
        chk("rej_wrPtr", 32'(wrPtr),    32'h80);
        chk("rej_ovf",   32'(overflow), 32'd1);
        chk("rej_state", 32'(wr_state), 32'd3);
        cyc();
        @(negedge wrclk);
        chk("rej_ovf_after", 32'(overflow), 32'(OVF_HOLD));
        chk("rej_state2",    32'(wr_state), 32'd3);

        // rdPtr jump 0x00 -> 0x50: level 90 -> 10 in the same cycle.
        cyc();
        rdPtr = 8'h50;
        @(negedge wrclk);
        chk("jump_level", 32'(level),       32'd10);
        chk("jump_full",  32'(fifo_full),   32'd0);
        chk("jump_afull", 32'(almost_full), 32'd0);
        chk("jump_state", 32'(wr_state),    32'd3);
        cyc();
        @(negedge wrclk);
        chk("jump_state_next", 32'(wr_state), 32'd1);

        // Full again, then a read lands on the edge of a rejected write.
        cyc();
        rdPtr = 8'h00;
        cyc();
        wren = 1'b1;
        @(negedge wrclk);
        chk("simul_reject", 32'(wr_accept), 32'd0);
        chk("simul_full",   32'(fifo_full), 32'd1);
        cyc();
        rdPtr = 8'h01;
        @(negedge wrclk);
        chk("simul_accept", 32'(wr_accept), 32'd1);
        chk("simul_level",  32'(level),     32'd89);
        chk("simul_ovf",    32'(overflow),  32'd1);
        cyc();
        wren = 1'b0;
        @(negedge wrclk);
        chk("simul_wrPtr", 32'(wrPtr),     32'h81);
        chk("simul_full2", 32'(fifo_full), 32'd1);

        // Wrap-around with rdPtr trailing by one entry.
        do_reset();
        wren = 1'b1;
        repeat (89) cyc();
        wren  = 1'b0;
        rdPtr = 8'h58;
        @(negedge wrclk);
        chk("wrap_pre_wrPtr", 32'(wrPtr), 32'h59);
        chk("wrap_pre_level", 32'(level), 32'd1);
        cyc();
        wren = 1'b1;
        @(negedge wrclk);
        chk("wrap_w1_accept", 32'(wr_accept), 32'd1);
        cyc();
        wren  = 1'b0;
        rdPtr = 8'h59;
        @(negedge wrclk);
        chk("wrap_wrPtr",   32'(wrPtr),   32'h80);
        chk("wrap_wr_addr", 32'(wr_addr), 32'h00);
        chk("wrap_level",   32'(level),   32'd1);
        cyc();
        rdPtr = 8'h80;
        @(negedge wrclk);
        chk("eq80_level", 32'(level),     32'd0);
        chk("eq80_full",  32'(fifo_full), 32'd0);
        cyc();
        wren = 1'b1;
        @(negedge wrclk);
        chk("eq80_state",  32'(wr_state),  32'd0);
        chk("eq80_accept", 32'(wr_accept), 32'd1);
        cyc();
        wren = 1'b0;
        @(negedge wrclk);
        chk("wrap81_wrPtr", 32'(wrPtr), 32'h81);
        chk("wrap81_level", 32'(level), 32'd1);

        // Asynchronous reset mid-burst at wrPtr = 0x23.
        do_reset();
        wren = 1'b1;
        repeat (35) cyc();
        #1;
        chk("rst_pre_wrPtr", 32'(wrPtr), 32'h23);
        wrrst = 1'b1;
        #1;
        chk("rst_wrPtr", 32'(wrPtr),    32'h00);
        chk("rst_addr",  32'(wr_addr),  32'h00);
        chk("rst_ovf",   32'(overflow), 32'd0);
        chk("rst_state", 32'(wr_state), 32'd0);
        cyc();
        wrrst = 1'b0;
        @(negedge wrclk);
        chk("rel_wrPtr0", 32'(wrPtr), 32'h00);
        cyc();
        wren = 1'b0;
        @(negedge wrclk);
        chk("rel_wrPtr1", 32'(wrPtr),   32'h01);
        chk("rel_addr1",  32'(wr_addr), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
